// File: rtl/pseq_pkg.sv
// Shared opcode constants, FSM state type and opcode decode helper for the
// program sequencer and the processor controller it feeds.
package pseq_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_LD,
    S_PRE,
    S_RUN,
    S_IMM_RD,
    S_IMM_LD,
    S_WAIT,
    S_HALTED
  } pseq_state_e;

  // Coarse class of a fetched word, used by the sequencer's LD state.
  typedef enum logic [1:0] {
    DEC_EXEC,
    DEC_IMM,
    DEC_HALT,
    DEC_ILLEGAL
  } pseq_dec_e;

  function automatic pseq_dec_e decode_op(input logic [OPC_W-1:0] op);
    pseq_dec_e d;
    case (op)
      OP_MV, OP_ADD, OP_SUB: d = DEC_EXEC;
      OP_MVI:                d = DEC_IMM;
      OP_HALT:               d = DEC_HALT;
      default:               d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// ROM read port plus the DIN/run/Done instruction handshake.
// master = sequencer side, slave = ROM/processor side.
interface prog_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 9
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] DIN;
  logic              run;
  logic              Done;

  modport master (
    output rom_addr,
    output DIN,
    output run,
    input  rom_data,
    input  Done
  );

  modport slave (
    input  rom_addr,
    input  DIN,
    input  run,
    output rom_data,
    output Done
  );

endinterface

// File: rtl/prog_sequencer.sv
// Instruction feeder: fetches from a synchronous ROM and issues each word on DIN
// with a one-cycle run pulse. Optional Done watchdog under `PSEQ_WDOG_EN.
module prog_sequencer
  import pseq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned WDOG_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_sequencer_if.master  bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  // A zero-length watchdog window is meaningless.
  if (WDOG_CYC == 0) begin : g_wdog_cfg_bad
    $error("prog_sequencer: WDOG_CYC must be nonzero");
  end

  pseq_state_e       state_q, state_d;
  logic [ADDR_W-1:0] pc_d, addr_d;
  logic [ADDR_W-1:0] pc_inc1, pc_inc2;
  logic [DATA_W-1:0] din_d;
  logic              err_d;
  logic              mvi_q, mvi_d;
  logic              run_d, busy_d, halted_d;
  pseq_dec_e         dec;

`ifdef PSEQ_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  // pc arithmetic wraps modulo 2**ADDR_W.
  assign pc_inc1 = pc + ADDR_W'(1);
  assign pc_inc2 = pc + ADDR_W'(2);
  assign dec     = decode_op(bus.rom_data[DATA_W-1 -: OPC_W]);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc           <= '0;
      bus.rom_addr <= '0;
      bus.DIN      <= '0;
      bus.run      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
      mvi_q        <= 1'b0;
`ifdef PSEQ_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      bus.rom_addr <= addr_d;
      bus.DIN      <= din_d;
      bus.run      <= run_d;
      busy         <= busy_d;
      halted       <= halted_d;
      err          <= err_d;
      mvi_q        <= mvi_d;
`ifdef PSEQ_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    addr_d  = bus.rom_addr;
    din_d   = bus.DIN;
    err_d   = err;
    mvi_d   = mvi_q;
`ifdef PSEQ_WDOG_EN
    wdog_d  = '0;
`endif

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          addr_d  = '0;
          err_d   = 1'b0;
          state_d = S_RD;
        end
      end

      S_RD: state_d = S_LD;

      S_LD: begin
        din_d = bus.rom_data;
        mvi_d = (dec == DEC_IMM);
        case (dec)
          DEC_EXEC, DEC_IMM: state_d = S_PRE;
          DEC_HALT:          state_d = S_HALTED;
          default: begin
            // Illegal word: flag it and skip to the next address.
            err_d   = 1'b1;
            pc_d    = pc_inc1;
            addr_d  = pc_inc1;
            state_d = S_RD;
          end
        endcase
      end

      S_PRE: state_d = S_RUN;

      S_RUN: begin
        if (mvi_q) begin
          addr_d  = pc_inc1;
          state_d = S_IMM_RD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_IMM_RD: state_d = S_IMM_LD;

      S_IMM_LD: begin
        din_d   = bus.rom_data;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.Done) begin
          pc_d    = mvi_q ? pc_inc2 : pc_inc1;
          addr_d  = pc_d;
          state_d = S_RD;
        end
`ifdef PSEQ_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
          // Processor never answered: stop with pc on the stalled instruction.
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase

    run_d    = (state_d == S_RUN);
    halted_d = (state_d == S_HALTED);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALTED);
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: ROM and processor models, expected-issue
// scoreboard per instance, plus a 2-bit-address instance for wrap-around.
module tb_prog_sequencer;

  typedef struct {
    logic [8:0] din;
    bit         mvi;
    logic [8:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  logic [4:0] pc1;
  logic [1:0] pc2;
  logic busy1, halted1, err1;
  logic busy2, halted2, err2;

  logic [8:0] rom1 [32];
  logic [8:0] rom2 [4];

  exp_t q1[$];
  exp_t q2[$];
  exp_t cur1, cur2;

  int checks = 0;
  int passes = 0;
  int runs1 = 0, runs2 = 0;
  int cnt1 = 0, cnt2 = 0, icnt1 = 0, icnt2 = 0;
  logic [8:0] prev1 = '0, prev2 = '0;
  bit hold_done = 1'b0;
  bit mdone = 1'b0;

  prog_sequencer_if #(.ADDR_W(5), .DATA_W(9)) if1 ();
  prog_sequencer_if #(.ADDR_W(2), .DATA_W(9)) if2 ();

  prog_sequencer #(.ADDR_W(5), .DATA_W(9), .WDOG_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start1), .bus(if1),
    .pc(pc1), .busy(busy1), .halted(halted1), .err(err1)
  );

  prog_sequencer #(.ADDR_W(2), .DATA_W(9), .WDOG_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(if2),
    .pc(pc2), .busy(busy2), .halted(halted2), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if1.rom_data <= rom1[if1.rom_addr];
  always @(posedge clk) if2.rom_data <= rom2[if2.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Processor model for the 5-bit instance: Done 2 cycles after run (4 for mvi).
  always @(negedge clk) begin
    logic d;
    d = 1'b0;
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) d = 1'b1;
    end
    if (icnt1 > 0) begin
      icnt1--;
      if (icnt1 == 0) chk("imm_at_run_plus3", 32'(if1.DIN), 32'(cur1.imm));
    end
    if (if1.run === 1'b1) begin
      runs1++;
      chk("run_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        cur1 = q1.pop_front();
        chk("din_at_run", 32'(if1.DIN), 32'(cur1.din));
        chk("din_held_before_run", 32'(prev1), 32'(if1.DIN));
        if (!hold_done) cnt1 = cur1.mvi ? 4 : 2;
        if (cur1.mvi) icnt1 = 3;
      end
    end
    if (d && cur1.mvi) chk("imm_held_at_done", 32'(if1.DIN), 32'(cur1.imm));
    prev1 = if1.DIN;
    if1.Done = d | mdone;
  end

  // Same processor model for the 2-bit wrap-around instance.
  always @(negedge clk) begin
    logic d;
    d = 1'b0;
    if (cnt2 > 0) begin
      cnt2--;
      if (cnt2 == 0) d = 1'b1;
    end
    if (icnt2 > 0) begin
      icnt2--;
      if (icnt2 == 0) chk("w_imm_at_run_plus3", 32'(if2.DIN), 32'(cur2.imm));
    end
    if (if2.run === 1'b1) begin
      runs2++;
      chk("w_run_expected", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        cur2 = q2.pop_front();
        chk("w_din_at_run", 32'(if2.DIN), 32'(cur2.din));
        chk("w_din_held_before_run", 32'(prev2), 32'(if2.DIN));
        cnt2 = cur2.mvi ? 4 : 2;
        if (cur2.mvi) icnt2 = 3;
      end
    end
    prev2 = if2.DIN;
    if2.Done = d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit sel);
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_halted(input bit sel, input int budget, input string tag);
    int n = 0;
    while (((sel ? halted2 : halted1) !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(sel ? halted2 : halted1), 32'd1);
  endtask

  task automatic chk_reset1(input string pfx);
    chk({pfx, "_pc"},     32'(pc1),          32'd0);
    chk({pfx, "_addr"},   32'(if1.rom_addr), 32'd0);
    chk({pfx, "_din"},    32'(if1.DIN),      32'd0);
    chk({pfx, "_run"},    32'(if1.run),      32'd0);
    chk({pfx, "_busy"},   32'(busy1),        32'd0);
    chk({pfx, "_halted"}, 32'(halted1),      32'd0);
    chk({pfx, "_err"},    32'(err1),         32'd0);
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 32; i++) rom1[i] = 9'h1C0;
    for (int i = 0; i < 4; i++)  rom2[i] = 9'h1C0;
    tick();
    tick();
    chk_reset1("reset");
    rst = 1'b0;
    tick();

    // mv then halt
    rom1[0] = 9'h00A;
    rom1[1] = 9'h1C0;
    q1.push_back('{din: 9'h00A, mvi: 1'b0, imm: 9'h000});
    r0 = runs1;
    pulse(1'b0);
    wait_halted(1'b0, 40, "mv_halted");
    chk("mv_pc", 32'(pc1), 32'd1);
    chk("mv_runs", 32'(runs1 - r0), 32'd1);
    chk("mv_err", 32'(err1), 32'd0);
    chk("mv_busy", 32'(busy1), 32'd0);

    // mvi with immediate, then halt at address 2
    rom1[0] = 9'h058;
    rom1[1] = 9'h05A;
    rom1[2] = 9'h1C0;
    q1.push_back('{din: 9'h058, mvi: 1'b1, imm: 9'h05A});
    r0 = runs1;
    pulse(1'b0);
    wait_halted(1'b0, 40, "mvi_halted");
    chk("mvi_pc", 32'(pc1), 32'd2);
    chk("mvi_runs", 32'(runs1 - r0), 32'd1);
    chk("mvi_queue_drained", 32'(q1.size()), 32'd0);

    // illegal opcode is skipped without a run
    rom1[0] = 9'h100;
    rom1[1] = 9'h1C0;
    r0 = runs1;
    pulse(1'b0);
    wait_halted(1'b0, 40, "ill_halted");
    chk("ill_runs", 32'(runs1 - r0), 32'd0);
    chk("ill_err", 32'(err1), 32'd1);
    chk("ill_pc", 32'(pc1), 32'd1);

    // reset in WAIT aborts; a late Done is ignored; restart from 0
    rom1[0] = 9'h088;
    rom1[1] = 9'h1C0;
    hold_done = 1'b1;
    q1.push_back('{din: 9'h088, mvi: 1'b0, imm: 9'h000});
    r0 = runs1;
    pulse(1'b0);
    repeat (8) tick();
    chk("wait_busy", 32'(busy1), 32'd1);
    chk("wait_err_cleared", 32'(err1), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset1("abort");
    mdone = 1'b1;
    tick();
    mdone = 1'b0;
    repeat (3) tick();
    chk("late_done_busy", 32'(busy1), 32'd0);
    chk("late_done_pc", 32'(pc1), 32'd0);
    chk("late_done_runs", 32'(runs1 - r0), 32'd1);
    hold_done = 1'b0;
    q1.push_back('{din: 9'h088, mvi: 1'b0, imm: 9'h000});
    pulse(1'b0);
    wait_halted(1'b0, 40, "restart_halted");
    chk("restart_pc", 32'(pc1), 32'd1);
    chk("restart_runs", 32'(runs1 - r0), 32'd2);

    // 2-bit address: mvi at address 3 takes its immediate from address 0
    rom2[0] = 9'h040;
    rom2[1] = 9'h1C0;
    rom2[2] = 9'h011;
    rom2[3] = 9'h058;
    q2.push_back('{din: 9'h040, mvi: 1'b1, imm: 9'h1C0});
    q2.push_back('{din: 9'h011, mvi: 1'b0, imm: 9'h000});
    q2.push_back('{din: 9'h058, mvi: 1'b1, imm: 9'h040});
    pulse(1'b1);
    wait_halted(1'b1, 80, "wrap_halted");
    chk("wrap_pc", 32'(pc2), 32'd1);
    chk("wrap_runs", 32'(runs2), 32'd3);
    chk("wrap_err", 32'(err2), 32'd0);

    // Done withheld
    rom1[0] = 9'h088;
    hold_done = 1'b1;
    q1.push_back('{din: 9'h088, mvi: 1'b0, imm: 9'h000});
    pulse(1'b0);
`ifdef PSEQ_WDOG_EN
    repeat (4 + 15) tick();
    chk("wdog_not_early", 32'(halted1), 32'd0);
    wait_halted(1'b0, 10, "wdog_halted");
    chk("wdog_err", 32'(err1), 32'd1);
    chk("wdog_pc", 32'(pc1), 32'd0);
`else
    repeat (60) tick();
    chk("nowdog_busy", 32'(busy1), 32'd1);
    chk("nowdog_halted", 32'(halted1), 32'd0);
    chk("nowdog_err", 32'(err1), 32'd0);
`endif
    hold_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
